reflet_vga_rect_fill: RTL and testbench

- Bus-mapped rectangle-fill engine that sits directly upstream of the VGA framebuffer write port.
- The CPU programs origin, size and colour through byte registers, then writes a start command.
- The engine then emits one framebuffer pixel write per clock, row-major, clipped to the 160x120 framebuffer.
- Top level muxes its pixel port into the framebuffer write port while busy=1.

---
 rtl/reflet_vga_rect_fill_pkg.sv | 14 +
 rtl/reflet_vga_rect_fill_if.sv | 15 +
 rtl/reflet_rw_register.sv | 12 +
 rtl/reflet_vga_fill_scan.sv | 40 ++++
 rtl/reflet_vga_rect_fill.sv | 76 +++++++
 tb/tb_reflet_vga_rect_fill.sv | 158 +++++++++++++++
 6 files changed

// File: rtl/reflet_vga_rect_fill_pkg.sv
// reflet_vga_rect_fill_pkg: framebuffer geometry, register map and FSM encoding for the rect-fill engine.
package reflet_vga_rect_fill_pkg;
  localparam int FB_WIDTH = 160;
  localparam int FB_HEIGHT = 120;
  localparam logic [2:0] REG_X = 3'd0;
  localparam logic [2:0] REG_Y = 3'd1;
  localparam logic [2:0] REG_W = 3'd2;
  localparam logic [2:0] REG_H = 3'd3;
  localparam logic [2:0] REG_COLOR = 3'd4;
  localparam logic [2:0] REG_CTRL = 3'd5;
  localparam int CTRL_START_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;
endpackage

// File: rtl/reflet_vga_rect_fill_if.sv
// reflet_vga_rect_fill_if: CPU byte bus plus framebuffer pixel write port of the rect-fill engine.
interface reflet_vga_rect_fill_if #(parameter int AW = 16);
  logic enable;
  logic [AW-1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic write_en;
  logic px_we;
  logic [7:0] px_h;
  logic [6:0] px_v;
  logic [5:0] px_color;
  logic busy;
  modport master (output enable, addr, data_in, write_en, input data_out, px_we, px_h, px_v, px_color, busy);
  modport slave (input enable, addr, data_in, write_en, output data_out, px_we, px_h, px_v, px_color, busy);
endinterface

// File: rtl/reflet_rw_register.sv
// reflet_rw_register: plain read/write register cell with synchronous reset to zero.
module reflet_rw_register #(parameter int W = 8) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_we,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk) r_q <= reset ? '0 : i_we ? i_d : r_q;
  assign o_q = r_q;
endmodule

// File: rtl/reflet_vga_fill_scan.sv
// reflet_vga_fill_scan: row-major column/row walker over [x0,x_end) x [y0,y_end); o_last flags the final pixel.
module reflet_vga_fill_scan (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [7:0] i_x0,
  input  logic [6:0] i_y0,
  input  logic [8:0] i_x_end,
  input  logic [8:0] i_y_end,
  output logic [7:0] o_col,
  output logic [6:0] o_row,
  output logic       o_last
);
  logic [7:0] r_col, r_x0;
  logic [6:0] r_row;
  logic [8:0] r_x_end, r_y_end;
  logic w_col_last;
  assign w_col_last = ({1'b0, r_col} + 9'd1) == r_x_end;
  assign o_last = w_col_last && (({2'b0, r_row} + 9'd1) == r_y_end);
  assign o_col = r_col;
  assign o_row = r_row;
  always_ff @(posedge clk)
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
      r_x0 <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
    end else if (i_load) begin
      r_col <= i_x0;
      r_row <= i_y0;
      r_x0 <= i_x0;
      r_x_end <= i_x_end;
      r_y_end <= i_y_end;
    end else if (i_step) begin
      r_col <= w_col_last ? r_x0 : r_col + 8'd1;
      r_row <= w_col_last ? r_row + 7'd1 : r_row;
    end
endmodule

// File: rtl/reflet_vga_rect_fill.sv
// reflet_vga_rect_fill: bus-programmed rectangle fill emitting one clipped framebuffer pixel write per clock.
module reflet_vga_rect_fill
  import reflet_vga_rect_fill_pkg::*;
#(
  parameter int base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr = 16'hFF28,
  parameter int fb_width = FB_WIDTH,
  parameter int fb_height = FB_HEIGHT
) (
  input logic clk,
  input logic reset,
  reflet_vga_rect_fill_if.slave bus
);
  state_t r_state;
  logic r_busy, r_done;
  logic [5:0] r_color;
  logic [base_addr_size-1:0] w_off;
  logic w_sel, w_wr, w_start, w_empty, w_last;
  logic [7:0] w_reg [4];
  logic [5:0] w_color;
  logic [8:0] w_x_sum, w_y_sum, w_x_end, w_y_end;
  logic [7:0] w_col;
  logic [6:0] w_row;
  assign w_off = bus.addr - base_addr;
  assign w_sel = bus.enable && (w_off < base_addr_size'(6));
  assign w_wr = w_sel && bus.write_en;
  genvar g;
  for (g = 0; g < 4; g++) begin : g_reg
    reflet_rw_register #(.W(8)) u_reg (
      .clk(clk), .reset(reset), .i_we(w_wr && w_off[2:0] == 3'(g)), .i_d(bus.data_in), .o_q(w_reg[g])
    );
  end
  reflet_rw_register #(.W(6)) u_color (
    .clk(clk), .reset(reset), .i_we(w_wr && w_off[2:0] == REG_COLOR), .i_d(bus.data_in[5:0]), .o_q(w_color)
  );
  // Sums are 9 bits wide so an origin near 255 plus a width cannot wrap into low columns.
  assign w_x_sum = {1'b0, w_reg[REG_X[1:0]]} + {1'b0, w_reg[REG_W[1:0]]};
  assign w_y_sum = {1'b0, w_reg[REG_Y[1:0]]} + {1'b0, w_reg[REG_H[1:0]]};
  assign w_x_end = w_x_sum > 9'(fb_width) ? 9'(fb_width) : w_x_sum;
  assign w_y_end = w_y_sum > 9'(fb_height) ? 9'(fb_height) : w_y_sum;
  assign w_empty = w_reg[REG_W[1:0]] == 8'd0 || w_reg[REG_H[1:0]] == 8'd0
                || {1'b0, w_reg[REG_X[1:0]]} >= 9'(fb_width) || {1'b0, w_reg[REG_Y[1:0]]} >= 9'(fb_height);
  assign w_start = w_wr && w_off[2:0] == REG_CTRL && bus.data_in[CTRL_START_BIT] && r_state == IDLE;
  reflet_vga_fill_scan u_scan (
    .clk(clk), .reset(reset), .i_load(w_start && !w_empty), .i_step(r_state == FILL && !w_last),
    .i_x0(w_reg[REG_X[1:0]]), .i_y0(w_reg[REG_Y[1:0]][6:0]), .i_x_end(w_x_end), .i_y_end(w_y_end),
    .o_col(w_col), .o_row(w_row), .o_last(w_last)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_color <= '0;
    end else if (r_state == IDLE) begin
      if (w_start) begin
        r_done <= w_empty;
        r_state <= w_empty ? IDLE : FILL;
        r_busy <= !w_empty;
        r_color <= w_empty ? r_color : w_color;
      end
    end else if (w_last) begin
      r_state <= IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b1;
    end
  assign bus.data_out = !w_sel ? 8'h00
                      : w_off[2:0] == REG_CTRL ? {6'b0, r_done, r_busy}
                      : w_off[2:0] == REG_COLOR ? {2'b0, w_color}
                      : w_reg[w_off[1:0]];
  assign bus.px_we = r_busy;
  assign bus.busy = r_busy;
  assign bus.px_h = w_col;
  assign bus.px_v = w_row;
  assign bus.px_color = r_color;
endmodule

// File: tb/tb_reflet_vga_rect_fill.sv
// tb_reflet_vga_rect_fill: table of fill rectangles with hand-computed pixel counts, plus reset and bus corner sequences.
module tb_reflet_vga_rect_fill;
  localparam logic [15:0] BASE = 16'hFF28;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int x, y, w, h, c, n;
    bit poke;
  } vec_t;
  vec_t vecs[10];
  reflet_vga_rect_fill_if bus ();
  reflet_vga_rect_fill dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.enable = 1'b1;
    bus.write_en = 1'b1;
    bus.addr = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    bus.write_en = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic en, input int exp);
    bus.enable = en;
    bus.addr = a;
    #1;
    chk(nm, int'(bus.data_out), exp);
    bus.enable = 1'b0;
  endtask

  task automatic run_fill(input vec_t v);
    int n = 0;
    int eh = v.x;
    int ev = v.y;
    int xe = (v.x + v.w > 160) ? 160 : v.x + v.w;
    wr(BASE + 0, 8'(v.x));
    wr(BASE + 1, 8'(v.y));
    wr(BASE + 2, 8'(v.w));
    wr(BASE + 3, 8'(v.h));
    wr(BASE + 4, 8'(v.c));
    wr(BASE + 5, 8'h01);
    for (int cyc = 0; cyc < v.n + 3; cyc++) begin
      @(negedge clk);
      chk("px_we", int'(bus.px_we), int'(cyc < v.n));
      chk("busy", int'(bus.busy), int'(cyc < v.n));
      if (bus.px_we) begin
        chk("px_h", int'(bus.px_h), eh);
        chk("px_v", int'(bus.px_v), ev);
        chk("px_color", int'(bus.px_color), v.c);
        n++;
        eh++;
        if (eh == xe) begin
          eh = v.x;
          ev++;
        end
      end
      if (cyc == 0) rd_chk("status_after_start", BASE + 5, 1'b1, v.n == 0 ? 2 : 1);
      if (v.poke && cyc == 20) begin
        bus.enable = 1'b1;
        bus.write_en = 1'b1;
        bus.addr = BASE + 4;
        bus.data_in = 8'h15;
      end
      if (v.poke && cyc == 21) begin
        bus.addr = BASE + 5;
        bus.data_in = 8'h01;
      end
      if (v.poke && cyc == 22) begin
        bus.enable = 1'b0;
        bus.write_en = 1'b0;
      end
    end
    chk("px_count", n, v.n);
    rd_chk("status_done", BASE + 5, 1'b1, 2);
    rd_chk("status_sticky", BASE + 5, 1'b1, 2);
    if (v.poke) rd_chk("color_updated", BASE + 4, 1'b1, 8'h15);
  endtask

  initial begin
    vecs[0] = '{x: 10, y: 20, w: 3, h: 2, c: 8'h2A, n: 6, poke: 0};
    vecs[1] = '{x: 158, y: 118, w: 5, h: 5, c: 8'h11, n: 4, poke: 0};
    vecs[2] = '{x: 5, y: 5, w: 0, h: 4, c: 8'h01, n: 0, poke: 0};
    vecs[3] = '{x: 200, y: 5, w: 3, h: 3, c: 8'h02, n: 0, poke: 0};
    vecs[4] = '{x: 250, y: 5, w: 20, h: 1, c: 8'h03, n: 0, poke: 0};
    vecs[5] = '{x: 0, y: 0, w: 1, h: 1, c: 8'h3F, n: 1, poke: 0};
    vecs[6] = '{x: 0, y: 119, w: 160, h: 1, c: 8'h07, n: 160, poke: 0};
    vecs[7] = '{x: 5, y: 5, w: 4, h: 0, c: 8'h08, n: 0, poke: 0};
    vecs[8] = '{x: 10, y: 130, w: 4, h: 4, c: 8'h09, n: 0, poke: 0};
    vecs[9] = '{x: 30, y: 10, w: 100, h: 100, c: 8'h05, n: 10000, poke: 1};
    bus.enable = 1'b0;
    bus.write_en = 1'b0;
    bus.addr = '0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_px_we", int'(bus.px_we), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_px_h", int'(bus.px_h), 0);
    chk("rst_px_v", int'(bus.px_v), 0);
    chk("rst_px_color", int'(bus.px_color), 0);
    for (int i = 0; i < 6; i++) rd_chk("rst_reg", BASE + 16'(i), 1'b1, 0);
    @(posedge clk);
    #1;
    wr(BASE + 0, 8'hA5);
    wr(BASE + 4, 8'hFF);
    rd_chk("reg_x", BASE, 1'b1, 8'hA5);
    rd_chk("color_mask", BASE + 4, 1'b1, 8'h3F);
    rd_chk("unsel_disabled", BASE, 1'b0, 0);
    rd_chk("unsel_above", BASE + 6, 1'b1, 0);
    rd_chk("unsel_below", BASE - 1, 1'b1, 0);
    wr(BASE + 5, 8'hFE);
    @(negedge clk);
    chk("no_start_bit0", int'(bus.busy), 0);
    rd_chk("status_no_start", BASE + 5, 1'b1, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) run_fill(vecs[i]);
    @(posedge clk);
    #1;
    wr(BASE + 0, 8'd0);
    wr(BASE + 1, 8'd0);
    wr(BASE + 2, 8'd100);
    wr(BASE + 3, 8'd100);
    wr(BASE + 4, 8'h07);
    wr(BASE + 5, 8'h01);
    repeat (50) @(negedge clk);
    chk("pre_reset_we", int'(bus.px_we), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_we", int'(bus.px_we), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_h", int'(bus.px_h), 0);
    chk("rst_mid_v", int'(bus.px_v), 0);
    chk("rst_mid_color", int'(bus.px_color), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_after_we", int'(bus.px_we), 0);
    end
    for (int i = 0; i < 6; i++) rd_chk("rst_mid_reg", BASE + 16'(i), 1'b1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
